// File: rtl/vx_bitmask_encoder.sv
// Streams the set-bit indices of an accepted bitmask, LANES indices per beat, in scan order.
// Optional macro VX_BITMASK_ENCODER_POPCOUNT_EN adds count_out (set-bit total of the accepted mask).
module vx_bitmask_encoder #(
    parameter int N       = 8,
    parameter int LANES   = 1,
    parameter int REVERSE = 0,
    parameter int LN      = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [N-1:0]          data_in,
    output logic                  ready_in,
    output logic                  valid_out,
    output logic [LANES*LN-1:0]   index_out,
    output logic [LANES-1:0]      lane_valid_out,
    output logic                  last_out,
`ifdef VX_BITMASK_ENCODER_POPCOUNT_EN
    output logic [$clog2(N+1)-1:0] count_out,
`endif
    input  logic                  ready_out
);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                state_q, state_d;
    logic [N-1:0]          mask_q, mask_d;
    logic [LANES*LN-1:0]   idx_q, idx_d;
    logic [LANES-1:0]      lv_q, lv_d;
    logic                  last_q, last_d;

    logic [N-1:0]          src_c, rest_c;
    logic [LANES*LN-1:0]   idx_c;
    logic [LANES-1:0]      lv_c;
    logic                  load_c;

    function automatic int scan_pos(input int i);
        return (REVERSE != 0) ? (N - 1 - i) : i;
    endfunction

    // Pick the next beat: the first LANES set bits of the source mask; rest_c is what remains.
    always_comb begin
        src_c  = (state_q == BUSY && !last_q) ? mask_q : data_in;
        rest_c = src_c;
        idx_c  = '0;
        lv_c   = '0;
        for (int k = 0; k < LANES; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!lv_c[k] && rest_c[scan_pos(i)]) begin
                    lv_c[k]              = 1'b1;
                    idx_c[k*LN +: LN]    = LN'(scan_pos(i));
                    rest_c[scan_pos(i)]  = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        lv_d    = lv_q;
        last_d  = last_q;
        load_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) load_c = 1'b1;
            end
            BUSY: begin
                if (ready_out) begin
                    if (!last_q || valid_in) begin
                        load_c = 1'b1;
                    end else begin
                        state_d = IDLE;
                        mask_d  = '0;
                        idx_d   = '0;
                        lv_d    = '0;
                        last_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load_c) begin
            state_d = BUSY;
            mask_d  = rest_c;
            idx_d   = idx_c;
            lv_d    = lv_c;
            last_d  = (rest_c == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            idx_q   <= '0;
            lv_q    <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            lv_q    <= lv_d;
            last_q  <= last_d;
        end
    end

`ifdef VX_BITMASK_ENCODER_POPCOUNT_EN
    localparam int unsigned CW = $clog2(N + 1);
    logic [CW-1:0] cnt_q, cnt_d, pop_c;

    // Population count is captured only when a fresh mask is accepted.
    always_comb begin
        pop_c = '0;
        for (int i = 0; i < N; i++) begin
            pop_c = pop_c + CW'(data_in[i]);
        end
        cnt_d = (valid_in && ready_in) ? pop_c : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign count_out = cnt_q;
`endif

    // ready_out reaches ready_in only to allow a zero-bubble hand-over on the last beat.
    assign ready_in       = (state_q == IDLE) || (ready_out && last_q);
    assign valid_out      = (state_q == BUSY);
    assign index_out      = idx_q;
    assign lane_valid_out = lv_q;
    assign last_out       = last_q;

endmodule

// File: tb/tb_vx_bitmask_encoder.sv
// Randomized + directed bench for vx_bitmask_encoder (N=8, LANES=2), ascending and descending instances
// checked against a queue-based model of the set-bit index stream.
module tb_vx_bitmask_encoder;

    localparam int N     = 8;
    localparam int LANES = 2;
    localparam int LN    = 3;

    logic clk = 1'b0;
    logic reset, valid_in, ready_out;
    logic [N-1:0] data_in;

    logic ready_in_f, valid_out_f, last_out_f;
    logic [LANES*LN-1:0] index_out_f;
    logic [LANES-1:0] lane_valid_out_f;
    logic ready_in_r, valid_out_r, last_out_r;
    logic [LANES*LN-1:0] index_out_r;
    logic [LANES-1:0] lane_valid_out_r;
`ifdef VX_BITMASK_ENCODER_POPCOUNT_EN
    logic [3:0] count_out_f, count_out_r;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vx_bitmask_encoder #(.N(N), .LANES(LANES), .REVERSE(0)) dut_f (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .ready_in(ready_in_f), .valid_out(valid_out_f), .index_out(index_out_f),
        .lane_valid_out(lane_valid_out_f), .last_out(last_out_f),
`ifdef VX_BITMASK_ENCODER_POPCOUNT_EN
        .count_out(count_out_f),
`endif
        .ready_out(ready_out)
    );

    vx_bitmask_encoder #(.N(N), .LANES(LANES), .REVERSE(1)) dut_r (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .ready_in(ready_in_r), .valid_out(valid_out_r), .index_out(index_out_r),
        .lane_valid_out(lane_valid_out_r), .last_out(last_out_r),
`ifdef VX_BITMASK_ENCODER_POPCOUNT_EN
        .count_out(count_out_r),
`endif
        .ready_out(ready_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: remaining indices of the held mask, in each scan order.
    bit busy = 1'b0;
    bit just_reset = 1'b0;
    int q_f[$];
    int q_r[$];
    int pop = 0;

    function automatic logic [LANES*LN-1:0] exp_idx(input int q[$]);
        logic [LANES*LN-1:0] v = '0;
        for (int k = 0; k < LANES; k++)
            if (k < q.size()) v[k*LN +: LN] = LN'(q[k]);
        return v;
    endfunction

    function automatic logic [LANES-1:0] exp_lv(input int n);
        logic [LANES-1:0] v = '0;
        for (int k = 0; k < LANES; k++)
            if (k < n) v[k] = 1'b1;
        return v;
    endfunction

    task automatic do_cycle(input bit v, input logic [N-1:0] d, input bit ro, input bit rst);
        bit exp_last, exp_rdy;
        @(negedge clk);
        reset = rst; valid_in = v; data_in = d; ready_out = ro;
        #1;
        exp_last = busy && (q_f.size() <= LANES);
        exp_rdy  = !busy || (ro && exp_last);
        check("valid_out_f", 32'(valid_out_f), 32'(busy));
        check("valid_out_r", 32'(valid_out_r), 32'(busy));
        check("ready_in_f", 32'(ready_in_f), 32'(exp_rdy));
        check("ready_in_r", 32'(ready_in_r), 32'(exp_rdy));
        if (busy) begin
            check("index_f", 32'(index_out_f), 32'(exp_idx(q_f)));
            check("index_r", 32'(index_out_r), 32'(exp_idx(q_r)));
            check("lanes_f", 32'(lane_valid_out_f), 32'(exp_lv(q_f.size())));
            check("lanes_r", 32'(lane_valid_out_r), 32'(exp_lv(q_r.size())));
            check("last_f", 32'(last_out_f), 32'(exp_last));
            check("last_r", 32'(last_out_r), 32'(exp_last));
`ifdef VX_BITMASK_ENCODER_POPCOUNT_EN
            check("count_f", 32'(count_out_f), 32'(pop));
            check("count_r", 32'(count_out_r), 32'(pop));
`endif
        end else if (just_reset) begin
            check("rst_index", 32'({index_out_f, index_out_r}), 32'(0));
            check("rst_lanes", 32'({lane_valid_out_f, lane_valid_out_r}), 32'(0));
            check("rst_last", 32'({last_out_f, last_out_r}), 32'(0));
        end
        @(posedge clk);
        just_reset = rst;
        if (rst) begin
            busy = 1'b0; q_f.delete(); q_r.delete();
        end else begin
            if (busy && ro) begin
                for (int k = 0; k < LANES; k++) begin
                    if (q_f.size() > 0) void'(q_f.pop_front());
                    if (q_r.size() > 0) void'(q_r.pop_front());
                end
                if (exp_last) busy = 1'b0;
            end
            if (v && exp_rdy) begin
                busy = 1'b1; q_f.delete(); q_r.delete(); pop = 0;
                for (int i = 0; i < N; i++) begin
                    if (d[i]) begin q_f.push_back(i); pop++; end
                    if (d[N-1-i]) q_r.push_back(N - 1 - i);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; data_in = '0; ready_out = 1'b0;
        @(posedge clk); @(posedge clk);
        just_reset = 1'b1;

        // Mixed mask, both scan orders, free-running consumer.
        do_cycle(1, 8'b1011_0010, 1, 0);
        do_cycle(0, 8'h00, 1, 0);
        do_cycle(0, 8'h00, 1, 0);
        do_cycle(0, 8'h00, 1, 0);

        // Single bit with a 3-cycle stall.
        do_cycle(1, 8'b0000_1000, 1, 0);
        repeat (3) do_cycle(0, 8'h00, 0, 0);
        do_cycle(0, 8'h00, 1, 0);
        do_cycle(0, 8'h00, 1, 0);

        // Empty mask then back-to-back single-bit masks.
        do_cycle(1, 8'h00, 1, 0);
        do_cycle(1, 8'h01, 1, 0);
        do_cycle(1, 8'h80, 1, 0);
        do_cycle(0, 8'h00, 1, 0);
        do_cycle(0, 8'h00, 1, 0);

        // Reset in the middle of a multi-beat mask.
        do_cycle(1, 8'hFF, 1, 0);
        do_cycle(0, 8'h00, 1, 0);
        do_cycle(0, 8'h00, 1, 1);
        do_cycle(1, 8'h00, 1, 0);
        do_cycle(0, 8'h00, 1, 0);

        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] d;
            d = N'($urandom);
            if ($urandom_range(0, 7) == 0) d = '0;
            do_cycle(bit'($urandom_range(0, 1)), d,
                     $urandom_range(0, 9) < 7, $urandom_range(0, 59) == 0);
        end
        repeat (6) do_cycle(0, 8'h00, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vx_bitmask_encoder.md
VX_BITMASK_ENCODER -- requirements
Module: VX_bitmask_encoder

Interface
REQ-001 SHALL have parameter N, default 8, meaning input mask width in bits (N >= 1).
REQ-002 SHALL have parameter LANES, default 1, meaning set-bit indices emitted per output beat (1 <= LANES <= N).
REQ-003 SHALL have parameter REVERSE, default 0, meaning 0 = lowest index first, 1 = highest index first.
REQ-004 SHALL have parameter LN, default LOG2UP(N), meaning index width.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-007 SHALL have port valid_in, input, 1, meaning data_in is valid.
REQ-008 SHALL have port data_in, input, N, meaning bitmask to encode.
REQ-009 SHALL have port ready_in, output, 1, meaning the block accepts data_in this cycle.
REQ-010 SHALL have port valid_out, output, 1, meaning the beat outputs are valid.
REQ-011 SHALL have port index_out, output, LANES*LN, meaning packed indices, lane 0 in LSBs.
REQ-012 SHALL have port lane_valid_out, output, LANES, meaning per-lane index valid.
REQ-013 SHALL have port last_out, output, 1, meaning final beat for the current mask.
REQ-014 SHALL have port ready_out, input, 1, meaning the consumer accepts the beat.

Function
REQ-015 SHALL use two states: IDLE (no mask held) and BUSY (mask held, beat presented).
REQ-016 SHALL complete an input handshake when valid_in && ready_in, latching data_in into the pending-mask register and entering BUSY.
REQ-017 SHALL assert ready_in in IDLE, or in BUSY when valid_out && ready_out && last_out (back-to-back, zero-bubble).
REQ-018 SHALL present the first beat one cycle after acceptance; valid_out = 1 in BUSY, 0 in IDLE.
REQ-019 SHALL fill lanes 0..LANES-1 with the first LANES set bits of the pending mask in scan order (ascending if REVERSE=0, descending if REVERSE=1).
REQ-020 SHALL drive lane_valid_out[k] = 1 only for filled lanes, with filled lanes contiguous from lane 0; unfilled index_out lanes SHALL be 0.
REQ-021 SHALL assert last_out when the pending mask holds <= LANES set bits.
REQ-022 SHALL hold index_out, lane_valid_out, last_out stable while valid_out && !ready_out.
REQ-023 SHALL on valid_out && ready_out clear the emitted bits; if last_out, load the new mask when valid_in is also high (stay BUSY), otherwise go IDLE.
REQ-024 SHALL accept an all-zero mask and emit exactly one beat with lane_valid_out = 0 and last_out = 1.
REQ-025 SHALL, for N=1, emit index 0 with lane 0 valid iff data_in[0] = 1.
REQ-026 SHALL produce outputs only from registered state, with no combinational path from data_in/valid_in to any output; ready_out SHALL reach ready_in combinationally only via REQ-017.

Reset
REQ-027 SHALL, with reset high at a clock edge, enter IDLE and clear pending mask, valid_out, lane_valid_out, index_out, last_out (and count_out when present) to 0.
REQ-028 SHALL, on reset mid-mask, discard remaining bits with no further beats; ready_in SHALL be 1 the cycle after reset deasserts.

Configuration
REQ-029 SHALL, with macro VX_BITMASK_ENCODER_POPCOUNT_EN defined, add output count_out (LOG2UP(N+1) bits), the total set bits of the accepted mask, valid and constant for every beat of that mask.
REQ-030 SHALL, without VX_BITMASK_ENCODER_POPCOUNT_EN, omit count_out and all popcount logic; other behaviour is identical.

Verification
REQ-031 SHALL cover N=8, LANES=2, REVERSE=0, data_in=8'b10110010, ready_out=1 -> beat1 indices {1,4}, lanes 2'b11, last 0; beat2 {5,7}, lanes 2'b11, last 1; count_out=4 when enabled.
REQ-032 SHALL cover REVERSE=1, same mask -> beat1 {7,5}, beat2 {4,1}, last on beat2.
REQ-033 SHALL cover data_in=8'b00001000 with ready_out low 3 cycles -> one beat {3,-}, lanes 2'b01, last 1, outputs stable while stalled, then IDLE.
REQ-034 SHALL cover data_in=0 -> one beat, lanes 2'b00, last 1; then masks 8'h01 and 8'h80 offered back-to-back -> ready_in high on each last beat, no idle cycle between beats.
REQ-035 SHALL cover reset asserted after beat1 of 8'hFF -> no further beats, valid_out 0 next cycle, ready_in 1 after reset deasserts.
